wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage directly downstream of the MEM stage. It merges the in-order MEM result stream (ALU result or load data) with out-of-order results from long-latency units (IMul, FPDiv) onto the single register-file write port. FU results are buffered in a 4-entry FIFO. The MEM stream is stalled only when that FIFO is full and a MEM write competes for the port.

## Interface
- DEPTH, 4: FU result FIFO entries (power of two)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Z_in  in  4  MEM destination register
- alu_in  in  32  MEM ALU result
- mem_in  in  32  MEM load data
- cntrl_w_in  in  4  [0] RegWrite, [1] MemToReg, [2] FP file select, [3] reserved (ignored)
- fu_valid_in  in  1  FU result valid
- fu_Z_in  in  4  FU destination register
- fu_data_in  in  32  FU result
- fu_fp_in  in  1  FU result targets the FP file
- fu_ready_out  out  1  FIFO can accept (not full)
- stall_out  out  1  MEM must hold its outputs this cycle
- rf_we_out  out  1  register-file write enable
- rf_fp_out  out  1  write targets the FP file
- rf_addr_out  out  4  write register
- rf_data_out  out  32  write data

## Operation
- MEM write request: mw = cntrl_w_in[0].
- MEM data: mem_in when cntrl_w_in[1] = 1, else alu_in.
- FU results are never written directly. An accepted beat (fu_valid_in & fu_ready_out) always enqueues, even when the FIFO is empty.
- fu_ready_out = (count != DEPTH).
- fu_valid_in while fu_ready_out = 0 is a protocol error. The beat is dropped and the FIFO is unchanged.
- Port selection each cycle, in priority order:
  1. FIFO full and mw: stall_out = 1. The FIFO head is written and the MEM beat is ignored. MEM re-presents the same beat next cycle.
  2. mw: the MEM beat is written and the FIFO holds.
  3. FIFO not empty: the head is written and dequeued.
  4. Otherwise: rf_we_out = 0.
- Enqueue and dequeue in the same cycle leave count unchanged; the pointers both advance and wrap mod DEPTH.
- stall_out is combinational from count and cntrl_w_in[0] only, not from fu_valid_in.
- WAW ordering between an in-flight FU result and a MEM write to the same register is the issue logic's responsibility. The block does not check it; a simulation-only assertion flags the same (addr, fp) pair being written on consecutive cycles from different sources.

## Timing
- Reset values: rf_we_out = 0, rf_fp_out = 0, rf_addr_out = 0, rf_data_out = 0, count = 0, pointers = 0, fu_ready_out = 1, stall_out = 0.
- rf_* outputs are registered, giving 1-cycle latency: a beat presented at edge n appears on rf_* after edge n+1.
- The minimum FU-to-RF latency is 2 cycles: enqueue at edge n, dequeue/write at edge n+1, visible after n+1.
- count updates on the same edge as the writeback. fu_ready_out reflects the post-edge count.
- Reset asserted mid-operation clears FIFO contents immediately. rf_we_out drops asynchronously, and no partial write is issued.
- After rst falls, the first accepted beat is on the next rising edge.

## Structure
- Package wb_pkg holds:
  - constants WB_REGWRITE = 0, WB_MEMTOREG = 1, WB_FPSEL = 2
  - DEPTH default
  - struct wb_entry_t {fp, addr[3:0], data[31:0]}
- Sub-module wb_result_fifo: synchronous DEPTH x 37-bit FIFO.
  - Ports: push, pop, din, dout, count, full, empty.
  - Async reset.
  - Head is visible combinationally; pop and push may occur in the same cycle.
- wb_stage contains the arbitration, the stall logic and the output register.

## Test plan
- Reset, then MEM load: Z_in = 3, alu_in = 12, mem_in = 0xDEAD, cntrl_w_in = 4'b0011 -> one cycle later rf_we_out = 1, rf_addr_out = 3, rf_data_out = 0xDEAD, rf_fp_out = 0.
- MEM store/nop (cntrl_w_in = 0) with an FU beat fu_Z_in = 5, fu_data_in = 0x41200000, fu_fp_in = 1 -> FIFO count 1, then next cycle rf_fp_out = 1, rf_addr_out = 5, data 0x41200000.
- Four FU beats 1..4 while MEM writes every cycle -> fu_ready_out = 0 after the 4th. The next MEM write sees stall_out = 1 and rf_* shows FU entry 1. The MEM beat is written the cycle after it is re-presented.
- Alternating MEM write and nop with 3 queued FU entries -> entries drain only in nop cycles, in FIFO order 1, 2, 3, with wrap-around verified over 10 beats.
- fu_valid_in while full -> beat dropped, count stays 4, no corruption of queued data.
- rst asserted with 2 FIFO entries and rf_we_out = 1 -> all outputs reset immediately, and no queued entry is written after rst falls.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback stage.
//   - control-word bit positions of cntrl_w_in
//   - default depth of the FU result FIFO
//   - wb_entry_t: one register-file write (target file, register, data)
package wb_pkg;

   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;
   localparam int WB_FPSEL    = 2;

   localparam int WB_DEPTH    = 4;

   typedef struct packed {
      logic        fp;
      logic [3:0]  addr;
      logic [31:0] data;
   } wb_entry_t;

   localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: synchronous DEPTH x WIDTH FIFO for long-latency FU results.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     enqueue request and data (ignored while full)
//   pop           dequeue request (ignored while empty)
//   dout          current head, visible combinationally
//   count         number of valid entries (0..DEPTH)
//   full, empty   status flags derived from count
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module wb_result_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int WIDTH = WB_ENTRY_W,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Contents are cleared on reset so nothing stale can ever surface as a head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         // Simultaneous push and pop leave the occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage merging the in-order MEM stream with buffered
// out-of-order FU results onto the single register-file write port.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   Z_in, alu_in, mem_in          MEM beat: destination, ALU result, load data
//   cntrl_w_in                    [0] RegWrite [1] MemToReg [2] FP select [3] unused
//   fu_valid_in, fu_Z_in,
//   fu_data_in, fu_fp_in          FU result beat
//   fu_ready_out                  FU result FIFO can accept a beat
//   stall_out                     MEM must hold and re-present its beat
//   rf_we_out, rf_fp_out,
//   rf_addr_out, rf_data_out      registered register-file write
//
// Handshake: an FU beat transfers on a rising edge where fu_valid_in and
// fu_ready_out are both high; fu_ready_out depends only on FIFO occupancy.
// A beat offered while fu_ready_out is low is dropped. The MEM stream has no
// valid/ready pair: stall_out high means the beat was not taken this edge.
module wb_stage
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  Z_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] mem_in,
   input  logic [3:0]  cntrl_w_in,
   input  logic        fu_valid_in,
   input  logic [3:0]  fu_Z_in,
   input  logic [31:0] fu_data_in,
   input  logic        fu_fp_in,
   output logic        fu_ready_out,
   output logic        stall_out,
   output logic        rf_we_out,
   output logic        rf_fp_out,
   output logic [3:0]  rf_addr_out,
   output logic [31:0] rf_data_out
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic                  mw;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic [CW-1:0]         fifo_count;
   logic [WB_ENTRY_W-1:0] head_bits;
   wb_entry_t             head;
   wb_entry_t             fu_entry;
   wb_entry_t             mem_entry;
   wb_entry_t             sel;
   logic                  sel_we;
   logic                  sel_src;   // 1 = FIFO head, 0 = MEM beat
   logic                  rf_src;    // source of the write currently on rf_*
   logic                  unused_bits;

   assign unused_bits = ^{cntrl_w_in[3], fifo_count};

   assign mw        = cntrl_w_in[WB_REGWRITE];
   assign head      = wb_entry_t'(head_bits);
   assign fu_entry  = '{fp: fu_fp_in, addr: fu_Z_in, data: fu_data_in};
   assign mem_entry = '{fp:   cntrl_w_in[WB_FPSEL],
                        addr: Z_in,
                        data: cntrl_w_in[WB_MEMTOREG] ? mem_in : alu_in};

   // Stall depends only on occupancy and the MEM request, never on fu_valid_in,
   // so MEM can use it without a combinational path through the FU side.
   assign fu_ready_out = ~full;
   assign stall_out    = full & mw;
   assign push         = fu_valid_in & ~full;

   wb_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WB_ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (fu_entry),
      .dout  (head_bits),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   // A full FIFO wins over MEM so it always drains; otherwise MEM has priority
   // and FU results fill idle slots.
   always_comb begin
      sel     = '0;
      sel_we  = 1'b0;
      sel_src = 1'b0;
      pop     = 1'b0;
      if (full && mw) begin
         sel     = head;
         sel_we  = 1'b1;
         sel_src = 1'b1;
         pop     = 1'b1;
      end else if (mw) begin
         sel     = mem_entry;
         sel_we  = 1'b1;
      end else if (!empty) begin
         sel     = head;
         sel_we  = 1'b1;
         sel_src = 1'b1;
         pop     = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_out   <= 1'b0;
         rf_fp_out   <= 1'b0;
         rf_addr_out <= '0;
         rf_data_out <= '0;
         rf_src      <= 1'b0;
      end else begin
         rf_we_out   <= sel_we;
         rf_fp_out   <= sel.fp;
         rf_addr_out <= sel.addr;
         rf_data_out <= sel.data;
         rf_src      <= sel_src;
      end
   end

`ifndef SYNTHESIS
   // WAW ordering is owned by issue; flag back-to-back writes of the same
   // register from different sources so an issue bug is visible in simulation.
   always @(posedge clk) begin
      if (!rst && rf_we_out && sel_we && (rf_src != sel_src)) begin
         assert (!((rf_fp_out == sel.fp) && (rf_addr_out == sel.addr)))
            else $error("wb_stage WAW hazard on fp=%0d reg=%0d", sel.fp, sel.addr);
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;

   logic        clk;
   logic        rst;
   logic [3:0]  Z_in;
   logic [31:0] alu_in;
   logic [31:0] mem_in;
   logic [3:0]  cntrl_w_in;
   logic        fu_valid_in;
   logic [3:0]  fu_Z_in;
   logic [31:0] fu_data_in;
   logic        fu_fp_in;
   logic        fu_ready_out;
   logic        stall_out;
   logic        rf_we_out;
   logic        rf_fp_out;
   logic [3:0]  rf_addr_out;
   logic [31:0] rf_data_out;

   int checks   = 0;
   int failures = 0;

   // Expected FIFO contents {fp, addr, data}, oldest first.
   logic [36:0] exp_q[$];

   logic [3:0]  drain_tab [0:4];
   logic [31:0] drop_tab  [0:2];

   wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .Z_in         (Z_in),
      .alu_in       (alu_in),
      .mem_in       (mem_in),
      .cntrl_w_in   (cntrl_w_in),
      .fu_valid_in  (fu_valid_in),
      .fu_Z_in      (fu_Z_in),
      .fu_data_in   (fu_data_in),
      .fu_fp_in     (fu_fp_in),
      .fu_ready_out (fu_ready_out),
      .stall_out    (stall_out),
      .rf_we_out    (rf_we_out),
      .rf_fp_out    (rf_fp_out),
      .rf_addr_out  (rf_addr_out),
      .rf_data_out  (rf_data_out)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic mem_set(input logic we, input logic m2r, input logic fp,
                          input logic [3:0] z, input logic [31:0] alu, input logic [31:0] md);
      cntrl_w_in = {1'b0, fp, m2r, we};
      Z_in       = z;
      alu_in     = alu;
      mem_in     = md;
   endtask

   task automatic fu_set(input logic v, input logic [3:0] z, input logic [31:0] d, input logic fp);
      fu_valid_in = v;
      fu_Z_in     = z;
      fu_data_in  = d;
      fu_fp_in    = fp;
   endtask

   task automatic idle();
      mem_set(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      fu_set(1'b0, 4'd0, 32'd0, 1'b0);
   endtask

   // One clock with the current inputs: predicts the port choice from the
   // priority rules, checks stall/ready before the edge and rf_*/count after.
   task automatic cycle(input string tag);
      logic        mw;
      logic        full;
      logic        exp_we;
      logic [36:0] e;
      #1;
      mw   = cntrl_w_in[0];
      full = (exp_q.size() == 4);
      chk({tag, " stall"}, {31'd0, stall_out}, {31'd0, full && mw});
      chk({tag, " ready"}, {31'd0, fu_ready_out}, {31'd0, !full});
      exp_we = 1'b1;
      e      = '0;
      if (full && mw) begin
         e = exp_q.pop_front();
      end else if (mw) begin
         e = {cntrl_w_in[2], Z_in, (cntrl_w_in[1] ? mem_in : alu_in)};
      end else if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
      end else begin
         exp_we = 1'b0;
      end
      if (fu_valid_in && !full) begin
         exp_q.push_back({fu_fp_in, fu_Z_in, fu_data_in});
      end
      @(posedge clk);
      #1;
      chk({tag, " we"}, {31'd0, rf_we_out}, {31'd0, exp_we});
      if (exp_we) begin
         chk({tag, " fp"},   {31'd0, rf_fp_out},   {31'd0, e[36]});
         chk({tag, " addr"}, {28'd0, rf_addr_out}, {28'd0, e[35:32]});
         chk({tag, " data"}, rf_data_out, e[31:0]);
      end
      chk({tag, " count"}, {29'd0, dut.u_fifo.count}, 32'(exp_q.size()));
   endtask

   initial begin
      drain_tab[0] = 4'd2; drain_tab[1] = 4'd3; drain_tab[2] = 4'd4;
      drain_tab[3] = 4'd5; drain_tab[4] = 4'd6;
      drop_tab[0] = 32'h502; drop_tab[1] = 32'h503; drop_tab[2] = 32'h504;

      // reset state
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst we",    {31'd0, rf_we_out},    32'd0);
      chk("rst fp",    {31'd0, rf_fp_out},    32'd0);
      chk("rst addr",  {28'd0, rf_addr_out},  32'd0);
      chk("rst data",  rf_data_out,           32'd0);
      chk("rst count", {29'd0, dut.u_fifo.count}, 32'd0);
      chk("rst ready", {31'd0, fu_ready_out}, 32'd1);
      chk("rst stall", {31'd0, stall_out},    32'd0);
      rst = 1'b0;

      // MEM load, ALU result, FP select, reserved bit alone
      mem_set(1'b1, 1'b1, 1'b0, 4'd3, 32'd12, 32'hDEAD);
      cycle("mem_load");
      chk("mem_load hand_data", rf_data_out, 32'hDEAD);
      chk("mem_load hand_addr", {28'd0, rf_addr_out}, 32'd3);
      mem_set(1'b1, 1'b0, 1'b0, 4'd4, 32'h12, 32'hDEAD);
      cycle("alu");
      chk("alu hand_data", rf_data_out, 32'h12);
      mem_set(1'b1, 1'b0, 1'b1, 4'd6, 32'h77, 32'd0);
      cycle("fpsel");
      chk("fpsel hand_fp", {31'd0, rf_fp_out}, 32'd1);
      mem_set(1'b0, 1'b0, 1'b0, 4'd7, 32'h99, 32'd0);
      cntrl_w_in = 4'b1000;
      cycle("reserved");
      chk("reserved hand_we", {31'd0, rf_we_out}, 32'd0);

      // single FU beat: enqueue, then write one cycle later
      mem_set(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      fu_set(1'b1, 4'd5, 32'h41200000, 1'b1);
      cycle("fu_enq");
      chk("fu_enq hand_count", {29'd0, dut.u_fifo.count}, 32'd1);
      fu_set(1'b0, 4'd0, 32'd0, 1'b0);
      cycle("fu_wr");
      chk("fu_wr hand_fp",   {31'd0, rf_fp_out}, 32'd1);
      chk("fu_wr hand_addr", {28'd0, rf_addr_out}, 32'd5);
      chk("fu_wr hand_data", rf_data_out, 32'h41200000);

      // fill FIFO with entries 1..4 while MEM writes every cycle
      for (int i = 1; i <= 4; i++) begin
         mem_set(1'b1, 1'b0, 1'b0, 4'(8 + i), 32'(32'h200 + i), 32'd0);
         fu_set(1'b1, 4'(i), 32'(32'h100 + i), 1'b0);
         cycle("fill");
      end
      chk("fill hand_ready", {31'd0, fu_ready_out}, 32'd0);

      // full + MEM write: stall, head written, MEM beat re-presented
      fu_set(1'b0, 4'd0, 32'd0, 1'b0);
      mem_set(1'b1, 1'b0, 1'b0, 4'd13, 32'h2AA, 32'd0);
      #1;
      chk("stall hand_hi", {31'd0, stall_out}, 32'd1);
      cycle("stall");
      chk("stall hand_addr", {28'd0, rf_addr_out}, 32'd1);
      chk("stall hand_data", rf_data_out, 32'h101);
      cycle("represent");
      chk("represent hand_data", rf_data_out, 32'h2AA);

      // alternate MEM write / nop: drain only in nops, with wrap-around
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) begin
            mem_set(1'b1, 1'b0, 1'b0, 4'(8 + i / 2), 32'(32'h400 + i), 32'd0);
            fu_set(1'b0, 4'd0, 32'd0, 1'b0);
         end else begin
            mem_set(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
            if (i < 6) fu_set(1'b1, 4'(4 + (i + 1) / 2), 32'(32'h300 + 4 + (i + 1) / 2), 1'b0);
            else       fu_set(1'b0, 4'd0, 32'd0, 1'b0);
         end
         cycle("alt");
         if (i % 2 == 1) begin
            chk("alt hand_order", {28'd0, rf_addr_out}, {28'd0, drain_tab[i / 2]});
         end
      end

      // refill to full, then offer a beat while full: it must be dropped
      for (int i = 0; i < 3; i++) begin
         mem_set(1'b1, 1'b0, 1'b0, 4'(13 + i), 32'(32'h600 + i), 32'd0);
         fu_set(1'b1, 4'(2 + i), 32'(32'h502 + i), 1'b0);
         cycle("refill");
      end
      chk("refill hand_count", {29'd0, dut.u_fifo.count}, 32'd4);
      mem_set(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      fu_set(1'b1, 4'd9, 32'hBAD, 1'b0);
      cycle("drop");
      chk("drop hand_data",  rf_data_out, 32'h307);
      chk("drop hand_count", {29'd0, dut.u_fifo.count}, 32'd3);
      fu_set(1'b0, 4'd0, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle("drain");
         chk("drain hand_data", rf_data_out, drop_tab[i]);
      end
      cycle("empty");
      chk("empty hand_we", {31'd0, rf_we_out}, 32'd0);

      // reset mid-operation with two queued entries and a live write
      mem_set(1'b1, 1'b0, 1'b0, 4'd9, 32'h700, 32'd0);
      fu_set(1'b1, 4'd1, 32'h801, 1'b0);
      cycle("pre_rst");
      mem_set(1'b1, 1'b0, 1'b0, 4'd10, 32'h701, 32'd0);
      fu_set(1'b1, 4'd2, 32'h802, 1'b0);
      cycle("pre_rst");
      chk("pre_rst hand_we", {31'd0, rf_we_out}, 32'd1);
      idle();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst we",    {31'd0, rf_we_out},    32'd0);
      chk("midrst data",  rf_data_out,           32'd0);
      chk("midrst addr",  {28'd0, rf_addr_out},  32'd0);
      chk("midrst count", {29'd0, dut.u_fifo.count}, 32'd0);
      chk("midrst ready", {31'd0, fu_ready_out}, 32'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle("post_rst");
      chk("post_rst hand_we", {31'd0, rf_we_out}, 32'd0);
      cycle("post_rst");
      mem_set(1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'd0);
      cycle("first_beat");
      chk("first_beat hand_data", rf_data_out, 32'h55);
      idle();

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
